spi_target_regs: RTL and testbench

- SPI mode-0 target (responder) that lets an external host read and write a small register file through the tile's uio pins.
- Sits inside the TinyTapeout top, between the uio pads and the core logic.
- SCLK, CS_N and MOSI are oversampled by the system clock. All internal logic runs on the single clock `clk`.

---
 rtl/spi_target_regs.sv | 181 ++++++++++++++++++
 tb/tb_spi_target_regs.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_target_regs.sv
// spi_target_regs: SPI mode-0 target giving an external host read/write access to a
// small register file. SCLK, CS_N and MOSI are oversampled by clk; everything runs on clk.
//
// Transaction: one command byte {rw, ..., addr[ADDR_W-1:0]} (rw=1 is a read), then
// data byte(s), all MSB first. Address NUM_REGS-1 is the read-only status register.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ena               tile enable; while low, CS_N is treated as high
//   spi_sclk/cs_n/mosi asynchronous SPI inputs
//   spi_miso, spi_miso_oe  MISO data and pad output enable
//   status_in         value returned on reads of the status address
//   regs_out          flattened register file, register 0 in [7:0], status slot reads 0
//   wr_strobe         one-cycle pulse per register write
//   wr_addr           address of the most recent write (held)
//
// Optional feature: define SPI_TARGET_AUTO_INC_EN to enable address auto-increment bursts
// (the address advances after each data byte and the transaction stays in the data phase).

module spi_target_regs #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oe,
    input  logic [7:0]            status_in,
    output logic [8*NUM_REGS-1:0] regs_out,
    output logic                  wr_strobe,
    output logic [ADDR_W-1:0]     wr_addr
);

    localparam int unsigned STATUS_IDX = NUM_REGS - 1;

    typedef enum logic [1:0] {StIdle, StCmd, StData, StDone} state_e;

    state_e              state_q;
    logic [2:0]          sclk_q;    // [1] synchronized, [2] previous for edge detection
    logic [1:0]          cs_n_q;
    logic [1:0]          mosi_q;
    logic [2:0]          bitcnt_q;
    logic [6:0]          cmd_sr_q;  // the 8th bit is consumed directly from mosi_q[1]
    logic [7:0]          rx_sr_q;
    logic [7:0]          tx_sr_q;   // kept at zero whenever no read data is being shifted
    logic                rw_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                wr_pend_q;
    logic [ADDR_W-1:0]   wr_pend_addr_q;
    logic [7:0]          regs_q [NUM_REGS-1];

    logic                cs_act;
    logic                sclk_rise;
    logic                sclk_fall;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [ADDR_W-1:0]   addr_inc;
    logic [7:0]          rx_next;

    assign cs_act    = ~cs_n_q[1] & ena;
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cmd_addr  = ADDR_W'({cmd_sr_q, mosi_q[1]});
    assign addr_inc  = addr_q + 1'b1;
    assign rx_next   = {rx_sr_q[6:0], mosi_q[1]};

    assign spi_miso    = tx_sr_q[7];
    assign spi_miso_oe = (state_q != StIdle);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        if (i < NUM_REGS - 1) begin : g_rw
            assign regs_out[8*i +: 8] = regs_q[i];
        end else begin : g_st
            assign regs_out[8*i +: 8] = 8'h00;
        end
    end

    function automatic logic [7:0] read_mux(input logic [ADDR_W-1:0] a);
        if (32'(a) < STATUS_IDX) begin
            return regs_q[a];
        end else if (32'(a) == STATUS_IDX) begin
            return status_in;
        end else begin
            return 8'h00;
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            sclk_q         <= 3'b000;
            cs_n_q         <= 2'b11;
            mosi_q         <= 2'b00;
            bitcnt_q       <= 3'd0;
            cmd_sr_q       <= 7'd0;
            rx_sr_q        <= 8'd0;
            tx_sr_q        <= 8'd0;
            rw_q           <= 1'b0;
            addr_q         <= '0;
            wr_pend_q      <= 1'b0;
            wr_pend_addr_q <= '0;
            wr_strobe      <= 1'b0;
            wr_addr        <= '0;
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            sclk_q <= {sclk_q[1:0], spi_sclk};
            cs_n_q <= {cs_n_q[0], spi_cs_n};
            mosi_q <= {mosi_q[0], spi_mosi};

            // A completed byte is committed one clk after its last bit, even if CS
            // rises in between.
            wr_pend_q <= 1'b0;
            wr_strobe <= 1'b0;
            if (wr_pend_q) begin
                regs_q[wr_pend_addr_q] <= rx_sr_q;
                wr_strobe              <= 1'b1;
                wr_addr                <= wr_pend_addr_q;
            end

            if (!cs_act) begin
                state_q <= StIdle;
                tx_sr_q <= 8'h00;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_q  <= StCmd;
                        bitcnt_q <= 3'd0;
                        tx_sr_q  <= 8'h00;
                    end
                    StCmd: begin
                        if (sclk_rise) begin
                            cmd_sr_q <= {cmd_sr_q[5:0], mosi_q[1]};
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                rw_q     <= cmd_sr_q[6];
                                addr_q   <= cmd_addr;
                                bitcnt_q <= 3'd0;
                                state_q  <= StData;
                                tx_sr_q  <= cmd_sr_q[6] ? read_mux(cmd_addr) : 8'h00;
                            end
                        end
                    end
                    StData: begin
                        if (sclk_rise) begin
                            rx_sr_q  <= rx_next;
                            bitcnt_q <= bitcnt_q + 3'd1;
                            if (bitcnt_q == 3'd7) begin
                                bitcnt_q <= 3'd0;
                                if (!rw_q && (32'(addr_q) < STATUS_IDX)) begin
                                    wr_pend_q      <= 1'b1;
                                    wr_pend_addr_q <= addr_q;
                                end
`ifdef SPI_TARGET_AUTO_INC_EN
                                addr_q  <= addr_inc;
                                tx_sr_q <= rw_q ? read_mux(addr_inc) : 8'h00;
`else
                                state_q <= StDone;
                                tx_sr_q <= 8'h00;
`endif
                            end
                        end else if (sclk_fall && (bitcnt_q != 3'd0)) begin
                            tx_sr_q <= {tx_sr_q[6:0], 1'b0};
                        end
                    end
                    StDone: begin
                        tx_sr_q <= 8'h00;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_target_regs.sv
// Self-checking bench for spi_target_regs: table of single-byte transactions, then
// hand-written sequences for partial bytes, bursts and mid-transfer reset.

module tb_spi_target_regs;

    logic        clk;
    logic        rst;
    logic        ena;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  status_in;
    logic [63:0] regs_out;
    logic        wr_strobe;
    logic [2:0]  wr_addr;

    spi_target_regs #(
        .NUM_REGS(8),
        .ADDR_W  (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .status_in  (status_in),
        .regs_out   (regs_out),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int strobe_cnt = 0;
    logic [2:0] last_wr_addr = 3'd0;
    logic [7:0] exp_r [8];

    // Counts high cycles, so a stretched pulse shows up as an extra strobe.
    always @(negedge clk) begin
        if (wr_strobe) begin
            strobe_cnt   = strobe_cnt + 1;
            last_wr_addr = wr_addr;
        end
    end

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic       ena;
        logic [7:0] status;
        logic [7:0] exp_rx;
        logic       do_wr;
        int         wr_idx;
    } vec_t;

    localparam int NV = 12;
    vec_t vec [NV];

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_exp();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[8*i +: 8] = exp_r[i];
        return p;
    endfunction

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_high();
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(8);
    endtask

    // Host side: MISO is captured just before each rising SCLK edge.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = tx[7-i];
            wait_clk(6);
            rx = {rx[6:0], spi_miso};
            spi_sclk = 1'b1;
            wait_clk(6);
            spi_sclk = 1'b0;
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] rx2;
        logic [7:0] rx3;
        int         s0;

        vec[0]  = '{8'h02, 8'hA5, 1'b1, 8'h00, 8'h00, 1'b1, 2};
        vec[1]  = '{8'h82, 8'h00, 1'b1, 8'h00, 8'hA5, 1'b0, 0};
        vec[2]  = '{8'h87, 8'h00, 1'b1, 8'h3C, 8'h3C, 1'b0, 0};
        vec[3]  = '{8'h07, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b0, 0};
        vec[4]  = '{8'h00, 8'h5A, 1'b1, 8'h00, 8'h00, 1'b1, 0};
        vec[5]  = '{8'h06, 8'h81, 1'b1, 8'h00, 8'h00, 1'b1, 6};
        vec[6]  = '{8'h80, 8'h00, 1'b1, 8'h00, 8'h5A, 1'b0, 0};
        vec[7]  = '{8'h01, 8'h77, 1'b0, 8'h00, 8'h00, 1'b0, 0};
        vec[8]  = '{8'h0B, 8'hC3, 1'b1, 8'h00, 8'h00, 1'b1, 3};
        vec[9]  = '{8'hF3, 8'h00, 1'b1, 8'h00, 8'hC3, 1'b0, 0};
        vec[10] = '{8'h86, 8'h00, 1'b1, 8'h00, 8'h81, 1'b0, 0};
        vec[11] = '{8'h84, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 0};

        for (int i = 0; i < 8; i++) exp_r[i] = 8'h00;

        rst       = 1'b1;
        ena       = 1'b1;
        spi_sclk  = 1'b0;
        spi_cs_n  = 1'b1;
        spi_mosi  = 1'b0;
        status_in = 8'h00;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);

        check("reset regs", regs_out, 64'h0);
        check("reset oe", {63'h0, spi_miso_oe}, 64'h0);
        check("reset miso", {63'h0, spi_miso}, 64'h0);
        check("reset wr_addr", {61'h0, wr_addr}, 64'h0);
        wait_clk(10);
        check("reset strobes", 64'(strobe_cnt), 64'h0);

        for (int v = 0; v < NV; v++) begin
            ena       = vec[v].ena;
            status_in = vec[v].status;
            s0        = strobe_cnt;
            cs_low();
            xfer(vec[v].cmd, 8, rx);
            check($sformatf("v%0d oe", v), {63'h0, spi_miso_oe}, {63'h0, vec[v].ena});
            xfer(vec[v].data, 8, rx);
            cs_high();
            check($sformatf("v%0d rx", v), {56'h0, rx}, {56'h0, vec[v].exp_rx});
            check($sformatf("v%0d strobes", v), 64'(strobe_cnt - s0), {63'h0, vec[v].do_wr});
            if (vec[v].do_wr) begin
                exp_r[vec[v].wr_idx] = vec[v].data;
                check($sformatf("v%0d wr_addr", v), {61'h0, last_wr_addr},
                      64'(vec[v].wr_idx));
            end
            check($sformatf("v%0d regs", v), regs_out, pack_exp());
            ena = 1'b1;
        end

        // CS rises after 5 data bits: the partial byte is discarded.
        s0 = strobe_cnt;
        cs_low();
        xfer(8'h01, 8, rx);
        xfer(8'h99, 5, rx);
        cs_high();
        check("partial strobes", 64'(strobe_cnt - s0), 64'h0);
        check("partial regs", regs_out, pack_exp());
        check("partial oe idle", {63'h0, spi_miso_oe}, 64'h0);

        // Burst starting at 6: the second byte lands on the status address and is dropped.
        s0 = strobe_cnt;
        cs_low();
        xfer(8'h06, 8, rx);
        xfer(8'h11, 8, rx);
        xfer(8'h22, 8, rx);
        cs_high();
        exp_r[6] = 8'h11;
        check("burst6 strobes", 64'(strobe_cnt - s0), 64'd1);
        check("burst6 wr_addr", {61'h0, last_wr_addr}, 64'd6);
        check("burst6 regs", regs_out, pack_exp());

        s0 = strobe_cnt;
        cs_low();
        xfer(8'h05, 8, rx);
        xfer(8'h33, 8, rx);
        xfer(8'h44, 8, rx);
        xfer(8'h55, 8, rx);
        cs_high();
        exp_r[5] = 8'h33;
`ifdef SPI_TARGET_AUTO_INC_EN
        exp_r[6] = 8'h44;
        check("burst5 strobes", 64'(strobe_cnt - s0), 64'd2);
        check("burst5 wr_addr", {61'h0, last_wr_addr}, 64'd6);
`else
        check("burst5 strobes", 64'(strobe_cnt - s0), 64'd1);
        check("burst5 wr_addr", {61'h0, last_wr_addr}, 64'd5);
`endif
        check("burst5 regs", regs_out, pack_exp());

        // Read burst from 5: only the first byte carries data without auto-increment.
        status_in = 8'h3C;
        cs_low();
        xfer(8'h85, 8, rx);
        xfer(8'h00, 8, rx);
        xfer(8'h00, 8, rx2);
        xfer(8'h00, 8, rx3);
        cs_high();
        check("rdburst b0", {56'h0, rx}, 64'h33);
`ifdef SPI_TARGET_AUTO_INC_EN
        check("rdburst b1", {56'h0, rx2}, 64'h44);
        check("rdburst b2", {56'h0, rx3}, 64'h3C);
`else
        check("rdburst b1", {56'h0, rx2}, 64'h00);
        check("rdburst b2", {56'h0, rx3}, 64'h00);
`endif

        // Reset in the middle of a write aborts it and clears the register file.
        s0 = strobe_cnt;
        cs_low();
        xfer(8'h01, 8, rx);
        xfer(8'hEE, 4, rx);
        rst = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        wait_clk(1);
        check("midrst regs", regs_out, 64'h0);
        check("midrst miso", {63'h0, spi_miso}, 64'h0);
        xfer(8'hEE, 8, rx);
        cs_high();
        check("midrst oe", {63'h0, spi_miso_oe}, 64'h0);
        check("midrst strobes", 64'(strobe_cnt - s0), 64'h0);
        check("midrst regs after", regs_out, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
